// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and serial-line signals of the UART transmit serializer.
// master: the byte producer; slave: the serializer.
interface uart_tx_serializer_if;
  logic [7:0] data_tx;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_bit;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output data_tx, tx_start,
    input  tx_ready, tx_bit, tx_busy, tx_done
  );

  modport slave (
    input  data_tx, tx_start,
    output tx_ready, tx_bit, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: 8N1/8N2 frames, LSB first, each bit held
// OVERSAMPLE clk_sample cycles, with a one-byte hold register so a second
// byte can be queued while a frame is on the line.
//
// state | meaning
// IDLE  | line high, nothing to send
// START | start bit (0) on the line
// DATA  | data bits, shift_q[0] on the line
// STOP  | stop bit(s) (1) on the line
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_sample,
  input  logic                 RST,
  uart_tx_serializer_if.slave  bus
);

  localparam int              CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   CNT_PRE   = CW'(OVERSAMPLE - 2);
  localparam logic            STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic          stop_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    hold_q;
  logic          hold_vld_q;
  logic          tx_bit_q;
  logic          tx_done_q;

  logic          handshake;
  logic          bit_end;
  logic          frame_end;

  assign handshake = bus.tx_start & ~hold_vld_q;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == STOP) && (stop_idx_q == STOP_LAST) && bit_end;

  // Frame sequencing, bit timing, hold buffer and registered line outputs.
  always_ff @(posedge clk_sample) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tx_bit_q   <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      // Registered, so raised one cycle early to land in the final stop cycle.
      tx_done_q <= (state_q == STOP) && (stop_idx_q == STOP_LAST) && (cnt_q == CNT_PRE);

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (hold_vld_q) begin
            shift_q    <= hold_q;
            hold_vld_q <= 1'b0;
            tx_bit_q   <= 1'b0;
            state_q    <= START;
          end else if (bus.tx_start) begin
            shift_q  <= bus.data_tx;
            tx_bit_q <= 1'b0;
            state_q  <= START;
          end
        end

        START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_bit_q  <= shift_q[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              stop_idx_q <= 1'b0;
              tx_bit_q   <= 1'b1;
              state_q    <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_bit_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_idx_q == STOP_LAST) begin
              // Queued byte (or a byte offered right now) follows with no gap.
              if (hold_vld_q) begin
                shift_q    <= hold_q;
                hold_vld_q <= 1'b0;
                tx_bit_q   <= 1'b0;
                state_q    <= START;
              end else if (bus.tx_start) begin
                shift_q  <= bus.data_tx;
                tx_bit_q <= 1'b0;
                state_q  <= START;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              stop_idx_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase

      // A byte accepted mid-frame waits in the hold register.
      if ((state_q != IDLE) && handshake && !frame_end) begin
        hold_q     <= bus.data_tx;
        hold_vld_q <= 1'b1;
      end
    end
  end

  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.tx_ready = ~hold_vld_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a default instance (16x, 1 stop) and a
// 4x / 2-stop instance, each with a byte scoreboard and a line monitor that
// checks every cycle of every frame against the expected waveform.
module tb_uart_tx_serializer;

  logic clk;
  logic rst;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();

  uart_tx_serializer #(.OVERSAMPLE(16), .STOP_BITS(1)) dut0 (
    .clk_sample (clk),
    .RST        (rst),
    .bus        (if0.slave)
  );

  uart_tx_serializer #(.OVERSAMPLE(4), .STOP_BITS(2)) dut1 (
    .clk_sample (clk),
    .RST        (rst),
    .bus        (if1.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int exp_frames0 = 0;
  int exp_frames1 = 0;
  int done_cnt0   = 0;
  int done_cnt1   = 0;
  logic mon_en0   = 1'b1;
  logic mon_en1   = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_bit(input int inst);
    return (inst == 0) ? if0.tx_bit : if1.tx_bit;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? if0.tx_done : if1.tx_done;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? if0.tx_busy : if1.tx_busy;
  endfunction

  function automatic logic get_ready(input int inst);
    return (inst == 0) ? if0.tx_ready : if1.tx_ready;
  endfunction

  always @(negedge clk) begin
    if (if0.tx_done === 1'b1) done_cnt0++;
    if (if1.tx_done === 1'b1) done_cnt1++;
  end

  // Called at the negedge of the first start-bit cycle; returns at the
  // negedge of the frame's last cycle.
  task automatic mon_frame(input int inst, input int os, input int sb);
    logic [7:0] exp_b;
    logic [7:0] rx_b;
    logic       eb;
    int         len;
    int         idx;
    int         bit_err;
    int         done_err;
    int         busy_err;
    len      = (9 + sb) * os;
    bit_err  = 0;
    done_err = 0;
    busy_err = 0;
    rx_b     = 8'h00;
    exp_b    = 8'h00;
    if (inst == 0) begin
      if (q0.size() == 0) chk("sb0_underflow", 32'(q0.size()), 32'd1);
      else exp_b = q0.pop_front();
    end else begin
      if (q1.size() == 0) chk("sb1_underflow", 32'(q1.size()), 32'd1);
      else exp_b = q1.pop_front();
    end
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      idx = c / os;
      if (idx == 0)      eb = 1'b0;
      else if (idx <= 8) eb = exp_b[idx-1];
      else               eb = 1'b1;
      if (get_bit(inst) !== eb) bit_err++;
      if ((c % os == os / 2) && idx >= 1 && idx <= 8) rx_b[idx-1] = get_bit(inst);
      if (get_done(inst) !== (c == len - 1)) done_err++;
      if (get_busy(inst) !== 1'b1) busy_err++;
    end
    chk($sformatf("rx_byte%0d", inst), 32'(rx_b), 32'(exp_b));
    chk($sformatf("line_cycles%0d", inst), 32'(bit_err), 32'd0);
    chk($sformatf("done_pos%0d", inst), 32'(done_err), 32'd0);
    chk($sformatf("busy_frame%0d", inst), 32'(busy_err), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en0 && !rst && if0.tx_bit === 1'b0) mon_frame(0, 16, 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en1 && !rst && if1.tx_bit === 1'b0) mon_frame(1, 4, 2);
    end
  end

  // Offer a byte at the next negedge; exp_acc is what the bench expects of tx_ready.
  task automatic send(input int inst, input logic [7:0] b, input logic exp_acc, input logic push);
    @(negedge clk);
    chk($sformatf("ready_pre%0d", inst), 32'(get_ready(inst)), 32'(exp_acc));
    if (inst == 0) begin if0.data_tx = b; if0.tx_start = 1'b1; end
    else           begin if1.data_tx = b; if1.tx_start = 1'b1; end
    @(posedge clk);
    #1;
    if (inst == 0) begin if0.tx_start = 1'b0; if0.data_tx = 8'($urandom); end
    else           begin if1.tx_start = 1'b0; if1.data_tx = 8'($urandom); end
    if (exp_acc && push) begin
      if (inst == 0) begin q0.push_back(b); exp_frames0++; end
      else           begin q1.push_back(b); exp_frames1++; end
    end
  endtask

  // Returns at the negedge where tx_done is high.
  task automatic wait_done(input int inst, input int max_cyc);
    bool_loop: for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (get_done(inst) === 1'b1) return;
    end
    chk($sformatf("done_timeout%0d", inst), 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst = 1'b1;
    if0.tx_start = 1'b0; if0.data_tx = 8'h00;
    if1.tx_start = 1'b0; if1.data_tx = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_bit",   32'(if0.tx_bit),   32'd1);
    chk("rst_busy",  32'(if0.tx_busy),  32'd0);
    chk("rst_ready", 32'(if0.tx_ready), 32'd1);
    chk("rst_done",  32'(if0.tx_done),  32'd0);

    // Single byte, latency of one cycle from handshake.
    send(0, 8'hA5, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_bit",   32'(if0.tx_bit),   32'd0);
    chk("lat_busy",  32'(if0.tx_busy),  32'd1);
    chk("lat_ready", 32'(if0.tx_ready), 32'd1);
    wait_done(0, 200);
    @(negedge clk);
    chk("idle_busy", 32'(if0.tx_busy), 32'd0);
    chk("idle_bit",  32'(if0.tx_bit),  32'd1);

    // Back-to-back through the hold register plus a refused third byte.
    send(0, 8'h00, 1'b1, 1'b1);
    send(0, 8'hFF, 1'b1, 1'b1);
    send(0, 8'h5A, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    chk("hold_ready_low", 32'(if0.tx_ready), 32'd0);
    wait_done(0, 200);
    chk("ready_low_end", 32'(if0.tx_ready), 32'd0);
    @(negedge clk);
    chk("ready_back", 32'(if0.tx_ready), 32'd1);
    chk("zero_gap",   32'(if0.tx_bit),   32'd0);
    wait_done(0, 200);
    @(negedge clk);
    chk("b2b_idle", 32'(if0.tx_busy), 32'd0);

    // Handshake in the last stop cycle with the hold register empty.
    send(0, 8'hC3, 1'b1, 1'b1);
    wait_done(0, 200);
    chk("last_ready", 32'(if0.tx_ready), 32'd1);
    if0.data_tx = 8'h96; if0.tx_start = 1'b1;
    @(posedge clk);
    #1 if0.tx_start = 1'b0; if0.data_tx = 8'h00;
    q0.push_back(8'h96); exp_frames0++;
    @(negedge clk);
    chk("direct_gap", 32'(if0.tx_bit), 32'd0);
    wait_done(0, 200);
    repeat (5) @(negedge clk);

    // Reset during data bit 4 of 8'h3C, with tx_start held during reset.
    mon_en0 = 1'b0;
    send(0, 8'h3C, 1'b1, 1'b0);
    repeat (16 + 4 * 16 + 5) @(negedge clk);
    chk("pre_rst_busy", 32'(if0.tx_busy), 32'd1);
    dc = done_cnt0;
    rst = 1'b1; if0.tx_start = 1'b1; if0.data_tx = 8'h11;
    @(posedge clk);
    #1 rst = 1'b0; if0.tx_start = 1'b0;
    @(negedge clk);
    chk("abort_bit",   32'(if0.tx_bit),   32'd1);
    chk("abort_busy",  32'(if0.tx_busy),  32'd0);
    chk("abort_ready", 32'(if0.tx_ready), 32'd1);
    repeat (200) @(negedge clk);
    chk("abort_no_done",  32'(done_cnt0),     32'(dc));
    chk("rst_start_ign",  32'(if0.tx_busy),   32'd0);
    mon_en0 = 1'b1;
    send(0, 8'h3C, 1'b1, 1'b1);
    wait_done(0, 200);

    // 4x oversample, two stop bits.
    send(1, 8'h81, 1'b1, 1'b1);
    wait_done(1, 60);
    @(negedge clk);
    chk("i1_idle", 32'(if1.tx_busy), 32'd0);
    send(1, 8'h7E, 1'b1, 1'b1);
    send(1, 8'hE7, 1'b1, 1'b1);
    wait_done(1, 60);
    wait_done(1, 60);
    repeat (10) @(negedge clk);

    chk("sb0_empty", 32'(q0.size()), 32'd0);
    chk("sb1_empty", 32'(q1.size()), 32'd0);
    chk("done_count0", 32'(done_cnt0), 32'(exp_frames0));
    chk("done_count1", 32'(done_cnt1), 32'(exp_frames1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
